// File: rtl/ram4x16_bank.sv
// Four-word register bank with combinational read and clocked write.
// A small sequencer clears all words to CLR_VAL on request and reports busy, done and drop.
module ram4x16_bank #(
  parameter int unsigned           WIDTH   = 16,
  parameter logic [WIDTH-1:0]      CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [1:0]       address,
  output logic [WIDTH-1:0] out,
  input  logic             clr,
  output logic             busy,
  output logic             done,
  output logic             drop
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state, state_nxt;
  logic [1:0]       cnt, cnt_nxt;
  logic             busy_nxt, done_nxt, drop_nxt;
  logic [3:0]       wen;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] words [4];

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    drop_nxt  = 1'b0;
    wen       = 4'b0000;
    wdata     = in;
    case (state)
      IDLE: begin
        drop_nxt = load & clr;
        if (clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = 2'd0;
        end else if (load) begin
          wen = 4'b0001 << address;
        end
      end
      CLEAR: begin
        // The clear owns the write port; a load here is reported and discarded.
        drop_nxt = load;
        wen      = 4'b0001 << cnt;
        wdata    = CLR_VAL;
        cnt_nxt  = cnt + 2'd1;
        if (cnt == 2'd3) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == CLEAR);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      drop  <= drop_nxt;
    end
  end

  // NOTE: the word array is reset because it is four flop words, not a RAM macro; out must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) words[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) words[i] <= wdata;
      end
    end
  end

  always_comb begin
    case (address)
      2'd0:    out = words[0];
      2'd1:    out = words[1];
      2'd2:    out = words[2];
      default: out = words[3];
    endcase
  end

endmodule

// File: tb/tb_ram4x16_bank.sv
// Self-checking bench for ram4x16_bank: directed scenarios then random traffic,
// compared against a queue-based model of the bank and its clear sequence.
module tb_ram4x16_bank;

  localparam logic [15:0] CLR = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in;
  logic        load;
  logic [1:0]  address;
  logic [15:0] out;
  logic        clr;
  logic        busy, done, drop;

  ram4x16_bank #(.WIDTH(16), .CLR_VAL(CLR)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .load(load), .address(address),
    .out(out), .clr(clr), .busy(busy), .done(done), .drop(drop)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: word contents, plus the list of words a running clear has yet to write.
  logic [15:0] m_mem [4];
  int          pending[$];
  logic        exp_done, exp_drop;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_mem[i] = '0;
    pending.delete();
    exp_done = 1'b0;
    exp_drop = 1'b0;
  endtask

  task automatic model_edge(input logic l, input logic c, input logic [1:0] a, input logic [15:0] d);
    bit idle;
    int w;
    idle     = (pending.size() == 0);
    exp_drop = l && (!idle || c);
    exp_done = 1'b0;
    if (!idle) begin
      w = pending.pop_front();
      m_mem[w] = CLR;
      if (pending.size() == 0) exp_done = 1'b1;
    end else if (c) begin
      pending = '{0, 1, 2, 3};
    end else if (l) begin
      m_mem[a] = d;
    end
  endtask

  task automatic check_state(input string tag);
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      check($sformatf("%s out[%0d]", tag, a), out, m_mem[a]);
    end
    check({tag, " busy"}, 16'(busy), 16'(pending.size() != 0));
    check({tag, " done"}, 16'(done), 16'(exp_done));
    check({tag, " drop"}, 16'(drop), 16'(exp_drop));
  endtask

  task automatic cycle(input logic l, input logic c, input logic [1:0] a, input logic [15:0] d,
                       input string tag);
    load = l; clr = c; address = a; in = d;
    @(posedge clk);
    model_edge(l, c, a, d);
    @(negedge clk);
    check_state(tag);
  endtask

  // Assert reset a few ns after a falling edge, check immediately, release on the next falling edge.
  task automatic mid_reset(input string tag);
    load = 1'b0; clr = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    check_state(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; load = 1'b0; clr = 1'b0; address = 2'd0; in = '0;
    model_reset();
    @(negedge clk);
    mid_reset("reset");

    // Write/read
    cycle(1'b1, 1'b0, 2'd1, 16'hA5A5, "wr1");
    cycle(1'b1, 1'b0, 2'd3, 16'h1234, "wr3");
    address = 2'd1; #1 check("rd1 const", out, 16'hA5A5);
    address = 2'd3; #1 check("rd3 const", out, 16'h1234);
    address = 2'd0; #1 check("rd0 const", out, 16'h0000);

    // Fill then clear
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 2'(i), 16'(i + 1), "fill");
    cycle(1'b0, 1'b1, 2'd0, '0, "clr start");
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 2'd0, '0, $sformatf("clr step%0d", i));
    cycle(1'b0, 1'b0, 2'd0, '0, "clr idle");

    // Load during clear
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 2'(i), 16'(16'h10 + i), "refill");
    cycle(1'b0, 1'b1, 2'd0, '0, "clr2 start");
    cycle(1'b0, 1'b0, 2'd0, '0, "clr2 b1");
    cycle(1'b1, 1'b0, 2'd2, 16'hFFFF, "clr2 load");
    cycle(1'b0, 1'b0, 2'd0, '0, "clr2 b3");
    cycle(1'b0, 1'b0, 2'd0, '0, "clr2 end");
    cycle(1'b0, 1'b0, 2'd0, '0, "clr2 after");

    // Simultaneous clr and load in IDLE
    cycle(1'b1, 1'b0, 2'd1, 16'hBEEF, "pre");
    cycle(1'b1, 1'b1, 2'd1, 16'hCAFE, "clr+load");
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 2'd1, '0, "clr3 run");

    // Clear request held high across sequences
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 2'd0, '0, "clr held");
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 2'd0, '0, "held drain");

    // Reset mid-clear
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 2'(i), 16'(16'h50 + i), "fill4");
    cycle(1'b0, 1'b1, 2'd0, '0, "clr4 start");
    cycle(1'b0, 1'b0, 2'd0, '0, "clr4 b2");
    mid_reset("mid-clear reset");
    cycle(1'b1, 1'b0, 2'd2, 16'h7777, "post-reset load");
    cycle(1'b0, 1'b0, 2'd0, '0, "post-reset idle");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        mid_reset("rand reset");
      end else begin
        cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
              16'($urandom), "rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
